// File: rtl/tl_pkg.sv
// Shared types and default timing for the intersection phase scheduler.
// Light encodings match the lamp driver wiring below the scheduler.
package tl_pkg;

    typedef enum logic [1:0] {
        LightGreen  = 2'b00,
        LightYellow = 2'b01,
        LightRed    = 2'b10
    } light_t;

    typedef enum logic [2:0] {
        PhAllRed   = 3'd0,
        PhNsGreen  = 3'd1,
        PhNsYellow = 3'd2,
        PhEwGreen  = 3'd3,
        PhEwYellow = 3'd4,
        PhPedWalk  = 3'd5
    } phase_t;

    typedef enum logic [1:0] {
        OwnerNs  = 2'd0,
        OwnerEw  = 2'd1,
        OwnerPed = 2'd2
    } owner_t;

    localparam int unsigned DefMinGreen   = 2;
    localparam int unsigned DefMaxGreen   = 5;
    localparam int unsigned DefYellowTime = 1;
    localparam int unsigned DefAllRedTime = 1;
    localparam int unsigned DefWalkTime   = 3;
    localparam int unsigned DefTimerW     = 8;

endpackage

// File: rtl/tl_rr_arbiter3.sv
// Combinational 3-way round-robin arbiter; search starts just after the last owner served.
// Request/grant bit order: [0]=NS, [1]=EW, [2]=PED.
module tl_rr_arbiter3
    import tl_pkg::*;
(
    input  logic [2:0] req_i,
    input  owner_t     last_served_i,
    output logic [2:0] grant_o,
    output logic       valid_o
);

    always_comb begin
        grant_o = 3'b000;
        valid_o = |req_i;
        case (last_served_i)
            OwnerNs: begin
                if (req_i[1])      grant_o = 3'b010;
                else if (req_i[2]) grant_o = 3'b100;
                else if (req_i[0]) grant_o = 3'b001;
            end
            OwnerEw: begin
                if (req_i[2])      grant_o = 3'b100;
                else if (req_i[0]) grant_o = 3'b001;
                else if (req_i[1]) grant_o = 3'b010;
            end
            default: begin
                if (req_i[0])      grant_o = 3'b001;
                else if (req_i[1]) grant_o = 3'b010;
                else if (req_i[2]) grant_o = 3'b100;
            end
        endcase
    end

endmodule

// File: rtl/intersection_phase_scheduler.sv
// Phase FSM for a two-approach intersection with a pedestrian crossing.
// Owners rotate NS -> EW -> PED; every handover goes through yellow and all-red.
module intersection_phase_scheduler
    import tl_pkg::*;
#(
    parameter int unsigned MIN_GREEN    = DefMinGreen,
    parameter int unsigned MAX_GREEN    = DefMaxGreen,
    parameter int unsigned YELLOW_TIME  = DefYellowTime,
    parameter int unsigned ALL_RED_TIME = DefAllRedTime,
    parameter int unsigned WALK_TIME    = DefWalkTime,
    parameter int unsigned TIMER_W      = DefTimerW
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ns_car_req,
    input  logic       ew_car_req,
    input  logic       ped_btn,
    output logic [1:0] ns_light,
    output logic [1:0] ew_light,
    output logic       ped_walk,
    output logic [2:0] phase
);

    // Thresholds are "last cycle" values: the phase ends on the edge after timer reaches them.
    localparam logic [TIMER_W-1:0] MinGreenLast = TIMER_W'(MIN_GREEN - 1);
    localparam logic [TIMER_W-1:0] MaxGreenLast = TIMER_W'(MAX_GREEN - 1);
    localparam logic [TIMER_W-1:0] YellowLast   = TIMER_W'(YELLOW_TIME - 1);
    localparam logic [TIMER_W-1:0] AllRedLast   = TIMER_W'(ALL_RED_TIME - 1);
    localparam logic [TIMER_W-1:0] WalkLast     = TIMER_W'(WALK_TIME - 1);

    phase_t              phase_q, phase_d;
    logic [TIMER_W-1:0]  timer_q, timer_d;
    logic                ped_pending_q, ped_pending_d;
    owner_t              last_served_q, last_served_d;

    logic [2:0]          arb_grant;
    logic                arb_valid;

    tl_rr_arbiter3 u_arb (
        .req_i         ({ped_pending_q, ew_car_req, ns_car_req}),
        .last_served_i (last_served_q),
        .grant_o       (arb_grant),
        .valid_o       (arb_valid)
    );

    always_comb begin
        phase_d       = phase_q;
        last_served_d = last_served_q;
        unique case (phase_q)
            PhNsGreen: begin
                if ((timer_q >= MinGreenLast && (ew_car_req || ped_pending_q)) ||
                    timer_q >= MaxGreenLast) begin
                    phase_d = PhNsYellow;
                end
            end
            PhEwGreen: begin
                if ((timer_q >= MinGreenLast && (ns_car_req || ped_pending_q)) ||
                    timer_q >= MaxGreenLast) begin
                    phase_d = PhEwYellow;
                end
            end
            PhNsYellow, PhEwYellow: begin
                if (timer_q >= YellowLast) phase_d = PhAllRed;
            end
            PhPedWalk: begin
                if (timer_q >= WalkLast) phase_d = PhAllRed;
            end
            PhAllRed: begin
                if (timer_q >= AllRedLast && arb_valid) begin
                    if (arb_grant[0]) begin
                        phase_d       = PhNsGreen;
                        last_served_d = OwnerNs;
                    end else if (arb_grant[1]) begin
                        phase_d       = PhEwGreen;
                        last_served_d = OwnerEw;
                    end else begin
                        phase_d       = PhPedWalk;
                        last_served_d = OwnerPed;
                    end
                end
            end
            default: phase_d = PhAllRed;
        endcase

        if (phase_d != phase_q) begin
            timer_d = '0;
        end else if (timer_q == '1) begin
            timer_d = timer_q;
        end else begin
            timer_d = timer_q + 1'b1;
        end

        // Entering walk serves the request, absorbing a same-cycle press too.
        ped_pending_d = ped_pending_q;
        if (phase_d == PhPedWalk && phase_q != PhPedWalk) begin
            ped_pending_d = 1'b0;
        end else if (phase_q != PhPedWalk && ped_btn) begin
            ped_pending_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase_q       <= PhAllRed;
            timer_q       <= '0;
            ped_pending_q <= 1'b0;
            last_served_q <= OwnerPed;
        end else begin
            phase_q       <= phase_d;
            timer_q       <= timer_d;
            ped_pending_q <= ped_pending_d;
            last_served_q <= last_served_d;
        end
    end

    always_comb begin
        ns_light = LightRed;
        ew_light = LightRed;
        ped_walk = 1'b0;
        unique case (phase_q)
            PhNsGreen:  ns_light = LightGreen;
            PhNsYellow: ns_light = LightYellow;
            PhEwGreen:  ew_light = LightGreen;
            PhEwYellow: ew_light = LightYellow;
            PhPedWalk:  ped_walk = 1'b1;
            default:    ;
        endcase
    end

    assign phase = phase_q;

endmodule

// File: tb/tb_intersection_phase_scheduler.sv
// Scoreboard bench: hand-derived phase sequences are queued per scenario, then popped and
// compared cycle by cycle against phase and light outputs.
module tb_intersection_phase_scheduler;
    import tl_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ns_car_req = 1'b0;
    logic       ew_car_req = 1'b0;
    logic       ped_btn = 1'b0;
    logic [1:0] ns_light;
    logic [1:0] ew_light;
    logic       ped_walk;
    logic [2:0] phase;

    int n_vec = 0;
    int n_err = 0;
    phase_t exp_q[$];

    intersection_phase_scheduler dut (
        .clk        (clk),
        .rst        (rst),
        .ns_car_req (ns_car_req),
        .ew_car_req (ew_car_req),
        .ped_btn    (ped_btn),
        .ns_light   (ns_light),
        .ew_light   (ew_light),
        .ped_walk   (ped_walk),
        .phase      (phase)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [1:0] exp_light(input phase_t p, input phase_t g, input phase_t y);
        if (p == g) return LightGreen;
        if (p == y) return LightYellow;
        return LightRed;
    endfunction

    task automatic expect_run(input phase_t p, input int n);
        repeat (n) exp_q.push_back(p);
    endtask

    // Called at a falling edge: compare this cycle, drive inputs for the coming edge.
    task automatic step(input string t, input int idx, input logic ns, input logic ew,
                        input logic ped);
        phase_t e;
        string  s;
        e = exp_q.pop_front();
        s = $sformatf("%s[%0d]", t, idx);
        check_eq({s, ".phase"}, {5'b0, phase}, {5'b0, e});
        check_eq({s, ".ns_light"}, {6'b0, ns_light}, {6'b0, exp_light(e, PhNsGreen, PhNsYellow)});
        check_eq({s, ".ew_light"}, {6'b0, ew_light}, {6'b0, exp_light(e, PhEwGreen, PhEwYellow)});
        check_eq({s, ".ped_walk"}, {7'b0, ped_walk}, {7'b0, e == PhPedWalk});
        ns_car_req = ns;
        ew_car_req = ew;
        ped_btn    = ped;
        @(negedge clk);
    endtask

    task automatic drain(input string t, input logic ns, input logic ew, input int press_a,
                         input int press_b);
        int idx;
        idx = 0;
        while (exp_q.size() > 0) begin
            step(t, idx, ns, ew, (idx == press_a) || (idx == press_b));
            idx++;
        end
    endtask

    task automatic do_reset();
        rst        = 1'b1;
        ns_car_req = 1'b0;
        ew_car_req = 1'b0;
        ped_btn    = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        // 1: idle
        do_reset();
        expect_run(PhAllRed, 10);
        drain("t1", 1'b0, 1'b0, -1, -1);

        // 2: NS alone runs to max green and is re-granted
        do_reset();
        expect_run(PhAllRed, 1);
        expect_run(PhNsGreen, 5);
        expect_run(PhNsYellow, 1);
        expect_run(PhAllRed, 1);
        expect_run(PhNsGreen, 2);
        drain("t2", 1'b1, 1'b0, -1, -1);

        // 3: NS and EW alternate at min green
        do_reset();
        expect_run(PhAllRed, 1);
        repeat (2) begin
            expect_run(PhNsGreen, 2);
            expect_run(PhNsYellow, 1);
            expect_run(PhAllRed, 1);
            expect_run(PhEwGreen, 2);
            expect_run(PhEwYellow, 1);
            expect_run(PhAllRed, 1);
        end
        expect_run(PhNsGreen, 1);
        drain("t3", 1'b1, 1'b1, -1, -1);

        // 4: ped press in NS green t=0; second press during walk is ignored
        do_reset();
        expect_run(PhAllRed, 1);
        expect_run(PhNsGreen, 2);
        expect_run(PhNsYellow, 1);
        expect_run(PhAllRed, 1);
        expect_run(PhPedWalk, 3);
        expect_run(PhAllRed, 1);
        expect_run(PhNsGreen, 5);
        expect_run(PhNsYellow, 1);
        expect_run(PhAllRed, 1);
        expect_run(PhNsGreen, 1);
        drain("t4", 1'b1, 1'b0, 1, 6);

        // 5: all three pending -> NS, EW, PED, NS
        do_reset();
        expect_run(PhAllRed, 1);
        expect_run(PhNsGreen, 2);
        expect_run(PhNsYellow, 1);
        expect_run(PhAllRed, 1);
        expect_run(PhEwGreen, 2);
        expect_run(PhEwYellow, 1);
        expect_run(PhAllRed, 1);
        expect_run(PhPedWalk, 3);
        expect_run(PhAllRed, 1);
        expect_run(PhNsGreen, 2);
        expect_run(PhNsYellow, 1);
        expect_run(PhAllRed, 1);
        expect_run(PhEwGreen, 1);
        drain("t5", 1'b1, 1'b1, 0, -1);

        // 6: async reset mid-walk, then no walk afterwards
        do_reset();
        expect_run(PhAllRed, 2);
        expect_run(PhPedWalk, 1);
        drain("t6a", 1'b0, 1'b0, 0, -1);
        check_eq("t6.walk_before_rst", {7'b0, ped_walk}, 8'd1);
        #2 rst = 1'b1;
        #1;
        check_eq("t6.rst_phase", {5'b0, phase}, {5'b0, PhAllRed});
        check_eq("t6.rst_ns", {6'b0, ns_light}, {6'b0, LightRed});
        check_eq("t6.rst_ew", {6'b0, ew_light}, {6'b0, LightRed});
        check_eq("t6.rst_walk", {7'b0, ped_walk}, 8'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        expect_run(PhAllRed, 6);
        drain("t6b", 1'b0, 1'b0, -1, -1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
